// File: rtl/rand_server.sv
// rand_server: round-robin arbiter sharing one 9-bit LFSR among NREQ
// requesters, reducing each decorrelated sample into [0, limit].
module rand_server #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int STEPS = 9
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [8:0]        rnd_in,
  input  logic [NREQ-1:0]   req,
  input  logic [9*NREQ-1:0] limit,
  output logic [NREQ-1:0]   ack,
  output logic [8:0]        value,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REDUCE,
    S_ACK
  } state_t;

  localparam logic [3:0]     STEPS_C = 4'(STEPS);
  localparam logic [IDW-1:0] LAST_R  = IDW'(NREQ - 1);

  state_t         state;
  state_t         nxt;
  logic [3:0]     fresh_cnt;
  logic [IDW-1:0] last_id;
  logic [8:0]     lim;
  logic [8:0]     work;
  logic           win_ok;
  logic [IDW-1:0] win_id;
  logic           capture;
  logic           fits;
  logic [9:0]     lim_p1;
  int             rr_idx;

  assign capture = (state == S_WAIT) &&
                   (fresh_cnt == STEPS_C);
  assign fits    = (work <= lim);
  assign lim_p1  = {1'b0, lim} + 10'd1;

  // Round-robin pick: nearest requester after last_id wins.
  always_comb begin
    win_ok = 1'b0;
    win_id = '0;
    rr_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = (int'(last_id) + k) % NREQ;
      if (req[rr_idx]) begin
        win_ok = 1'b1;
        win_id = IDW'(rr_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (win_ok)  nxt = S_WAIT;
      S_WAIT:   if (capture) nxt = S_REDUCE;
      S_REDUCE: if (fits)    nxt = S_ACK;
      S_ACK:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Freshness counter: cycles since the last captured sample.
  always_ff @(posedge CLK) begin
    if (!reset)
      fresh_cnt <= '0;
    else if (capture)
      fresh_cnt <= '0;
    else if (fresh_cnt != STEPS_C)
      fresh_cnt <= fresh_cnt + 4'd1;
  end

  // Grant latch, sample capture, modular reduction and ack pulse.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ack      <= '0;
      value    <= '0;
      grant_id <= '0;
      last_id  <= LAST_R;
      lim      <= '0;
      work     <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_ok) begin
            grant_id <= win_id;
            lim      <= limit[9*int'(win_id) +: 9];
          end
        end
        S_WAIT: begin
          if (capture) work <= rnd_in;
        end
        S_REDUCE: begin
          if (fits) begin
            value   <= work;
            ack     <= NREQ'(1) << grant_id;
            last_id <= grant_id;
          end else if (lim == 9'd0) begin
            work <= 9'd0;
          end else begin
            work <= 9'({1'b0, work} - lim_p1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rand_server.md
# rand_server

Round-robin server that shares the single free-running 9-bit LFSR random source among up to NREQ game requesters: ball-launch angle, bonus-target selection, bumper scoring and similar. Each grant waits until the LFSR has advanced STEPS times since the previous sample, so no two requesters ever receive correlated values. The server then reduces the sample into the requester's range [0, limit] by iterative subtraction and returns it through a req/ack handshake. It sits between the LFSR and the game-logic blocks that need random numbers.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: grant-id width, ceil(log2(NREQ)).
- STEPS, 9: minimum LFSR advances between two consecutive samples (1..15).
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- rnd_in  in  9  current LFSR output; advances every cycle, and no enable is driven.
- req  in  NREQ  level request per requester; held high until that requester's ack.
- limit  in  9*NREQ  per-requester inclusive upper bound; requester i uses bits [9i+8:9i].
- ack  out  NREQ  one-hot, one-cycle pulse; value is valid in this cycle.
- value  out  9  reduced random number; held until the next ack.
- grant_id  out  IDW  index of the requester currently or last served.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, REDUCE, ACK.
- fresh_cnt is a 4-bit counter.
  - It increments every cycle and saturates at STEPS.
  - It clears to 0 on the cycle a sample is captured.
- IDLE:
  - If any req bit is high, select the winner by round-robin, searching from last_id+1 upward with wrap-around.
  - Latch the winner into grant_id, latch its limit into lim, and go to WAIT.
  - If no req bit is high, stay in IDLE.
- WAIT:
  - If fresh_cnt == STEPS: work <= rnd_in, fresh_cnt <= 0, go to REDUCE.
  - Otherwise stay in WAIT.
- REDUCE:
  - If work <= lim: value <= work, ack[grant_id] <= 1, last_id <= grant_id, go to ACK.
  - Otherwise work <= work - (lim + 1), using 10-bit arithmetic for lim + 1, and stay in REDUCE.
  - lim = 0 is a special case: work <= 0 directly. It is never iterated.
- ACK: ack is high for exactly this cycle. Next state is IDLE.
- Requester obligation: deassert req on the edge that ends the ack cycle. If req is still high in IDLE, it counts as a new request.
- req deasserted after a grant is ignored; the transaction completes and ack still pulses.
- limit changes after the grant have no effect on the current transaction.
- The round-robin pointer updates only at ACK, never at the grant.
- Simultaneous requests: exactly one is granted per transaction; the others wait in order.
- lim = 511: the sample passes through unchanged.
- Reset, including mid-transaction:
  - state = IDLE, ack = 0, value = 0, grant_id = 0, busy = 0, fresh_cnt = 0, last_id = NREQ-1.
  - A partially served request is dropped. The requester must hold req and is re-arbitrated.
  - Requester 0 has first priority after reset.

## Timing
- Edge E1, req sampled in IDLE: grant.
- Edge E2: sample, provided fresh_cnt is saturated.
- Edge E3: ack registered. ack is high in the cycle after E3, with no subtraction.
- Each subtraction adds one cycle.
- An unsaturated fresh_cnt adds STEPS - fresh_cnt cycles in WAIT.
- Worst case per transaction: 3 + STEPS + floor(511/(lim+1)) cycles.
- Back-to-back service: IDLE follows ACK, so the next grant edge is one cycle after the ack cycle.
- The captured samples of consecutive transactions are at least STEPS cycles apart.
- value, ack, grant_id and busy are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold reset low for 5 cycles with req = 4'b1111.
  - All outputs stay 0 throughout.
  - After release, the first grant goes to requester 0, and the first sample waits until fresh_cnt reaches 9.
- Single request: req[2], limit = 99, bench forces rnd_in = 257 at capture, fresh_cnt saturated.
  - Two subtractions.
  - value = 57 and ack = 4'b0100, pulsing once, 5 cycles after grant.
- Boundary limits:
  - limit 511 with rnd_in 300 gives value 300 with no subtraction.
  - limit 0 with rnd_in 450 gives value 0 after one REDUCE cycle.
  - limit 99 with rnd_in 99 gives 99 with no subtraction.
- All four requesters held high continuously:
  - acks occur in order 0, 1, 2, 3, 0.
  - Consecutive capture edges are at least 9 cycles apart.
  - busy drops for exactly one IDLE cycle between transactions.
- Requester 1 drops req while in WAIT: the ack still pulses for requester 1, and value updates.
- Reset asserted mid-REDUCE with lim = 0x001 and work = 400:
  - Next cycle state is IDLE, ack and value are 0, and no ack is emitted.
  - The held req is re-granted after release.
